// File: rtl/vram_bus_pkg.sv
// Shared encodings for the VRAM bus arbiter: FSM states, owner codes, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_bus_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DATA_WIDTH   = 8;

  // Wide enough for MEM_LATENCY up to 7 and CPU_MAX_WAIT up to 15.
  localparam int LAT_CNT_WIDTH    = 3;
  localparam int STARVE_CNT_WIDTH = 4;

  localparam logic [1:0] BUS_IDLE   = 2'd0;
  localparam logic [1:0] BUS_ACCESS = 2'd1;
  localparam logic [1:0] BUS_DONE   = 2'd2;

  localparam logic OWNER_CHRONI = 1'b0;
  localparam logic OWNER_CPU    = 1'b1;

endpackage

// File: rtl/vram_arb_priority.sv
// Grant decision between Chroni and CPU: fixed Chroni priority with a CPU starvation guard.
// Latency: owner_o is combinational from the requests; the starve counter updates on idle cycles.
// Backpressure: none; the owner is only acted on when idle_i is high.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   chroni_req_i     Chroni read request (level)
//   cpu_req_i        CPU request (level)
//   idle_i           arbiter is in IDLE this cycle (grant opportunity)
//   owner_o          requester that wins if a grant happens this cycle
module vram_arb_priority
  import vram_bus_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic chroni_req_i,
  input  logic cpu_req_i,
  input  logic idle_i,
  output logic owner_o
);

  localparam logic [STARVE_CNT_WIDTH-1:0] MAX_WAIT = STARVE_CNT_WIDTH'(CPU_MAX_WAIT);

  logic [STARVE_CNT_WIDTH-1:0] starve_q, starve_d;

  // CPU wins when it is alone, or when Chroni has beaten it MAX_WAIT times in a row.
  always_comb begin
    owner_o = OWNER_CHRONI;
    if (cpu_req_i && (!chroni_req_i || (starve_q == MAX_WAIT))) begin
      owner_o = OWNER_CPU;
    end
  end

  // Counts Chroni grants taken while the CPU was waiting; saturates so the
  // forced CPU grant stays armed until it actually happens.
  always_comb begin
    starve_d = starve_q;
    if (idle_i) begin
      if (!cpu_req_i || (owner_o == OWNER_CPU)) begin
        starve_d = '0;
      end else if (starve_q != MAX_WAIT) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares one synchronous VRAM port between Chroni (read-only) and the CPU (read/write).
// Latency: read ack at grant+MEM_LATENCY+1 cycles, write ack at grant+2 cycles.
// Backpressure: level req / one-cycle ack; a held req simply waits until the next IDLE cycle.
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   chroni_rd_req_i, chroni_addr_i      Chroni read request and address
//   chroni_rd_ack_o, chroni_data_o      Chroni ack pulse and held read data
//   cpu_req_i, cpu_we_i, cpu_addr_i,
//   cpu_wdata_i                         CPU request, direction, address, write data
//   cpu_ack_o, cpu_rdata_o              CPU ack pulse and held read data
//   mem_cs_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i            VRAM port
//   busy_o                              high whenever a transaction is in flight
module vram_bus_arbiter
  import vram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY  = 2,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  chroni_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] chroni_addr_i,
  output logic                  chroni_rd_ack_o,
  output logic [DATA_WIDTH-1:0] chroni_data_o,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ack_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  // Counter value on the last ACCESS cycle of a read, when mem_rdata is valid.
  localparam logic [LAT_CNT_WIDTH-1:0] LAT_LAST = LAT_CNT_WIDTH'(MEM_LATENCY - 1);

  logic [1:0]               state_q, state_d;
  logic [LAT_CNT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
  logic                     owner_q;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [DATA_WIDTH-1:0]    chroni_data_q;
  logic [DATA_WIDTH-1:0]    cpu_rdata_q;

  logic idle;
  logic grant;
  logic grant_owner;
  logic rd_capture;

  assign idle       = (state_q == BUS_IDLE);
  assign grant      = idle && (chroni_rd_req_i || cpu_req_i);
  assign rd_capture = (state_q == BUS_ACCESS) && !we_q && (lat_cnt_q == LAT_LAST);

  vram_arb_priority #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) u_priority (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .chroni_req_i (chroni_rd_req_i),
    .cpu_req_i    (cpu_req_i),
    .idle_i       (idle),
    .owner_o      (grant_owner)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. DONE never arbitrates, so a req still high there waits one
  // cycle and is then seen fresh in IDLE.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      BUS_IDLE: begin
        lat_cnt_d = '0;
        if (chroni_rd_req_i || cpu_req_i) begin
          state_d = BUS_ACCESS;
        end
      end
      BUS_ACCESS: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (we_q || (lat_cnt_q == LAT_LAST)) begin
          state_d = BUS_DONE;
        end
      end
      BUS_DONE: begin
        state_d = BUS_IDLE;
      end
      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  // Outputs. Strobes decode from state so a reset drops them at the next edge;
  // only the owner recorded at grant can see the DONE-cycle ack.
  always_comb begin
    busy_o          = (state_q != BUS_IDLE);
    mem_cs_o        = (state_q == BUS_ACCESS);
    mem_we_o        = (state_q == BUS_ACCESS) && we_q;
    chroni_rd_ack_o = (state_q == BUS_DONE) && (owner_q == OWNER_CHRONI);
    cpu_ack_o       = (state_q == BUS_DONE) && (owner_q == OWNER_CPU);
    mem_addr_o      = mem_addr_q;
    mem_wdata_o     = mem_wdata_q;
    chroni_data_o   = chroni_data_q;
    cpu_rdata_o     = cpu_rdata_q;
  end

  // Datapath: request fields are sampled only at the grant; read data lands
  // only in the owner's register and only for reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lat_cnt_q     <= '0;
      owner_q       <= OWNER_CHRONI;
      we_q          <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      chroni_data_q <= '0;
      cpu_rdata_q   <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      if (grant) begin
        owner_q <= grant_owner;
        if (grant_owner == OWNER_CPU) begin
          mem_addr_q  <= cpu_addr_i;
          mem_wdata_q <= cpu_wdata_i;
          we_q        <= cpu_we_i;
        end else begin
          mem_addr_q  <= chroni_addr_i;
          we_q        <= 1'b0;
        end
      end
      if (rd_capture) begin
        if (owner_q == OWNER_CHRONI) begin
          chroni_data_q <= mem_rdata_i;
        end else begin
          cpu_rdata_q <= mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Self-checking bench for vram_bus_arbiter: directed vector table, multi-cycle
// corner sequences, a MEM_LATENCY=1 instance, and a randomized run against a
// transaction-level reference model.
module tb_vram_bus_arbiter;

  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance (MEM_LATENCY = 2)
  logic        c_req, c_ack, p_req, p_we, p_ack, m_cs, m_we, busy;
  logic [15:0] c_addr, p_addr, m_addr;
  logic [7:0]  c_data, p_wdata, p_rdata, m_wdata, m_rdata;

  // Second instance (MEM_LATENCY = 1)
  logic        c_req1, c_ack1, p_req1, p_we1, p_ack1, m_cs1, m_we1, busy1;
  logic [15:0] c_addr1, p_addr1, m_addr1;
  logic [7:0]  c_data1, p_wdata1, p_rdata1, m_wdata1, m_rdata1;

  vram_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(LAT), .CPU_MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .reset_i(reset),
    .chroni_rd_req_i(c_req), .chroni_addr_i(c_addr), .chroni_rd_ack_o(c_ack), .chroni_data_o(c_data),
    .cpu_req_i(p_req), .cpu_we_i(p_we), .cpu_addr_i(p_addr), .cpu_wdata_i(p_wdata),
    .cpu_ack_o(p_ack), .cpu_rdata_o(p_rdata),
    .mem_cs_o(m_cs), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
    .mem_rdata_i(m_rdata), .busy_o(busy)
  );

  vram_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(1), .CPU_MAX_WAIT(MAXW)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .chroni_rd_req_i(c_req1), .chroni_addr_i(c_addr1), .chroni_rd_ack_o(c_ack1), .chroni_data_o(c_data1),
    .cpu_req_i(p_req1), .cpu_we_i(p_we1), .cpu_addr_i(p_addr1), .cpu_wdata_i(p_wdata1),
    .cpu_ack_o(p_ack1), .cpu_rdata_o(p_rdata1),
    .mem_cs_o(m_cs1), .mem_we_o(m_we1), .mem_addr_o(m_addr1), .mem_wdata_o(m_wdata1),
    .mem_rdata_i(m_rdata1), .busy_o(busy1)
  );

  // Power-up VRAM contents: a fixed per-address pattern, with 0x41 at 0x0020.
  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h0020) return 8'h41;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // VRAM device model: writes on cs&we at the edge; read data valid
  // MEM_LATENCY-1 cycles after the address appears (one register for LAT=2).
  logic [7:0] vram     [0:65535];
  bit         vram_ok  [0:65535];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (m_cs && m_we) begin
      vram[m_addr]    <= m_wdata;
      vram_ok[m_addr] <= 1'b1;
    end
    rd_q <= vram_ok[m_addr] ? vram[m_addr] : pat(m_addr);
  end
  assign m_rdata  = rd_q;
  assign m_rdata1 = pat(m_addr1);

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated transaction from an IDLE cycle (cycle 0 = request cycle).
  task automatic do_single(input string nm, input bit is_cpu, input bit we, input logic [15:0] addr,
                           input logic [7:0] wd, input int lat, input logic [7:0] exp_d);
    int got;
    int other;
    got   = 0;
    other = 0;
    if (is_cpu) begin
      p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wd;
    end else begin
      c_req = 1'b1; c_addr = addr;
    end
    for (int k = 1; k <= 12 && got == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1 && is_cpu && we)
        chk({nm, "_memwrite"}, {m_cs, m_we, m_addr, m_wdata}, {1'b1, 1'b1, addr, wd});
      if (k == 2 && is_cpu && we)
        chk({nm, "_we_one_cycle"}, m_we, 0);
      if (is_cpu ? c_ack : p_ack) other++;
      if (is_cpu ? p_ack : c_ack) begin
        got   = k;
        c_req = 1'b0;
        p_req = 1'b0;
      end
    end
    chk({nm, "_latency"}, got, lat);
    chk({nm, "_other_ack"}, other, 0);
    if (!we) chk({nm, "_data"}, is_cpu ? p_rdata : c_data, exp_d);
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  typedef struct {
    bit          is_cpu;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [7];

  // Reference model state for the randomized phase
  logic [7:0]  ref_mem [16];
  bit          md_act, md_own, md_we;
  int          md_g, md_done, starve;
  logic [15:0] md_addr;
  logic [7:0]  md_wd, e_cd, e_cr;

  function automatic logic [15:0] rnd_addr();
    return 16'h0100 + 16'($urandom_range(0, 15));
  endfunction

  initial begin
    int seq [10];
    int n, both, last, cnt, got, other;
    logic [15:0] sa;
    bit idle_t, e_cack, e_pack, e_we, e_cs;

    c_req = 0; c_addr = 0; p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    c_req1 = 0; c_addr1 = 0; p_req1 = 0; p_we1 = 0; p_addr1 = 0; p_wdata1 = 0;

    //            cpu we  addr      wdata  lat data
    vecs[0] = '{1'b0, 1'b0, 16'h0020, 8'h00, 3, 8'h41};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 8'h5A, 2, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 16'h1234, 8'h00, 3, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 8'h00, 3, 8'h5A};
    vecs[4] = '{1'b1, 1'b1, 16'h0020, 8'hC3, 2, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 16'h0020, 8'h00, 3, 8'hC3};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 3, 8'h3C};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {c_ack, c_data, p_ack, p_rdata, m_cs, m_we, m_addr, m_wdata, busy}, 64'h0);
    reset = 1'b0;

    // Directed single transactions
    for (int i = 0; i < 7; i++)
      do_single($sformatf("vec%0d", i), vecs[i].is_cpu, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].lat, vecs[i].data);

    // Both requesting continuously: expect C,C,C,C,P,C,C,C,C,P
    c_req = 1; c_addr = 16'h0030; p_req = 1; p_we = 0; p_addr = 16'h0040;
    n = 0; both = 0;
    for (int k = 0; k < 120 && n < 10; k++) begin
      @(posedge clk); #1;
      if (c_ack && p_ack) both++;
      if (c_ack) begin seq[n] = 0; n++; end
      else if (p_ack) begin seq[n] = 1; n++; end
    end
    c_req = 0; p_req = 0;
    chk("starve_grants", n, 10);
    chk("starve_both_acks", both, 0);
    for (int i = 0; i < n; i++)
      chk($sformatf("starve_owner%0d", i), seq[i], (i % 5 == 4) ? 1 : 0);
    @(posedge clk); #1;

    // Chroni streaming: new address on each ack, one read every LAT+2 cycles
    sa = 16'h0010; c_req = 1; c_addr = sa; cnt = 0; last = 0;
    for (int k = 1; k < 80 && cnt < 6; k++) begin
      @(posedge clk); #1;
      if (c_ack) begin
        chk($sformatf("stream_data%0d", cnt), c_data, pat(sa));
        if (cnt > 0) chk($sformatf("stream_gap%0d", cnt), k - last, LAT + 2);
        last = k;
        cnt++;
        sa = sa + 16'h1;
        c_addr = sa;
        if (cnt == 6) c_req = 0;
      end
    end
    c_req = 0;
    chk("stream_count", cnt, 6);
    @(posedge clk); #1;

    // Reset during ACCESS of a CPU write
    p_req = 1; p_we = 1; p_addr = 16'h0200; p_wdata = 8'h77;
    @(posedge clk); #1;
    chk("rst_write_we_before", m_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_write_strobes", {m_we, m_cs, busy, p_ack, c_ack}, 0);
    chk("rst_write_rdata", p_rdata, 0);
    reset = 1'b0; p_req = 0; p_we = 0;
    do_single("post_reset_read", 1'b1, 1'b0, 16'h0300, 8'h00, 3, 8'h3F);

    // MEM_LATENCY = 1 instance
    c_req1 = 1; c_addr1 = 16'h0055; got = 0; other = 0;
    for (int k = 1; k <= 10 && got == 0; k++) begin
      @(posedge clk); #1;
      if (p_ack1) other++;
      if (c_ack1) begin got = k; c_req1 = 0; end
    end
    c_req1 = 0;
    chk("lat1_latency", got, 2);
    chk("lat1_data", c_data1, 8'h69);
    chk("lat1_other_ack", other, 0);

    // Randomized phase against the transaction-level model
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pat(16'(16'h0100 + i));
    md_act = 0; md_own = 0; md_we = 0; md_g = 0; md_done = 0; starve = 0;
    md_addr = 0; md_wd = 0; e_cd = 0; e_cr = 0;

    for (int t = 0; t < 1500; t++) begin
      // Expected outputs for cycle t
      idle_t = !md_act;
      e_cack = md_act && (t == md_done) && !md_own;
      e_pack = md_act && (t == md_done) && md_own;
      e_we   = md_act && md_we && (t == md_g + 1);
      e_cs   = md_act && (t < md_done);
      if (e_cack) e_cd = ref_mem[md_addr[3:0]];
      if (e_pack && !md_we) e_cr = ref_mem[md_addr[3:0]];
      chk($sformatf("rnd_ctrl@%0d", t), {busy, m_cs, m_we, c_ack, p_ack},
          {md_act, e_cs, e_we, e_cack, e_pack});
      chk($sformatf("rnd_data@%0d", t), {c_data, p_rdata}, {e_cd, e_cr});
      if (e_we) chk($sformatf("rnd_wr@%0d", t), {m_addr, m_wdata}, {md_addr, md_wd});
      if (md_act && t == md_done) md_act = 0;

      // Requesters react to acks they see this cycle
      if (c_ack) begin
        if ($urandom_range(0, 1) == 0) c_req = 0;
        else c_addr = rnd_addr();
      end else if (!c_req && $urandom_range(0, 2) == 0) begin
        c_req = 1; c_addr = rnd_addr();
      end
      if (p_ack) begin
        if ($urandom_range(0, 1) == 0) p_req = 0;
        else begin p_we = 1'($urandom_range(0, 1)); p_addr = rnd_addr(); p_wdata = 8'($urandom); end
      end else if (!p_req && $urandom_range(0, 2) == 0) begin
        p_req = 1; p_we = 1'($urandom_range(0, 1)); p_addr = rnd_addr(); p_wdata = 8'($urandom);
      end

      // Arbitration opportunity in idle cycles
      if (idle_t) begin
        if (c_req || p_req) begin
          if (c_req && p_req) begin
            if (starve == MAXW) begin md_own = 1; starve = 0; end
            else begin md_own = 0; starve = starve + 1; end
          end else begin
            md_own = p_req;
            starve = 0;
          end
          md_act  = 1;
          md_g    = t;
          md_we   = md_own && p_we;
          md_addr = md_own ? p_addr : c_addr;
          md_wd   = p_wdata;
          md_done = t + (md_we ? 2 : LAT + 1);
          if (md_we) ref_mem[p_addr[3:0]] = p_wdata;
        end else begin
          starve = 0;
        end
      end
      @(posedge clk); #1;
    end
    c_req = 0; p_req = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
